muller_c_bank: RTL and testbench

Clocked, multi-channel generalisation of the N-input Muller C-element. It provides M independent channels of N inputs each, with synchronised inputs, programmable asymmetric (plus/minus) input participation, per-channel transition pulses, and bank-wide completion flags. It sits between asynchronous handshake pads and synchronous user logic. It replaces ad-hoc single C-elements wherever the consumer is clocked.

---
 rtl/muller_c_bank.sv | 199 +++++++++++++++++++
 tb/tb_muller_c_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_bank.sv
// -----------------------------------------------------------------------------
// muller_c_bank
//
// Clocked bank of M independent N-input Muller C-elements. Each input bit is
// brought into the clk domain through a SYNC_STAGES-deep flop chain. The
// synchronised inputs are then qualified by shared rise/fall participation
// masks, which allows asymmetric C-elements:
//   - an output rises when every rise-selected input is 1;
//   - an output falls when every fall-selected input is 0;
//   - it holds otherwise.
//
// Configuration macro:
//   MULLER_C_BANK_CNT_EN : when defined, per-channel saturating transition
//                          counters (and their cnt_clr) are built. When
//                          undefined, trans_cnt is tied to zero and cnt_clr
//                          is ignored.
//
// Parameters:
//   N           inputs per channel (>=2)
//   M           channel count (>=1)
//   SYNC_STAGES synchroniser depth per input bit (>=2)
//   CNT_W       width of each transition counter (>=2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   io_in       [M*N]     channel m at [m*N +: N], asynchronous to clk
//   rise_mask   [N]       inputs taking part in the rising condition (shared)
//   fall_mask   [N]       inputs taking part in the falling condition (shared)
//   cnt_clr     synchronous clear of all transition counters
//   io_out      [M]       C-element state per channel (registered)
//   rise_pulse  [M]       one-cycle pulse in the cycle io_out[m] becomes 1
//   fall_pulse  [M]       one-cycle pulse in the cycle io_out[m] becomes 0
//   conflict    [M]       high for each cycle a hold was forced by R & F
//   all_high    &io_out
//   all_low     ~|io_out
//   trans_cnt   [M*CNT_W] per-channel transition count, channel m at
//                         [m*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module muller_c_bank #(
  parameter int N           = 6,
  parameter int M           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [M*N-1:0]     io_in,
  input  logic [N-1:0]       rise_mask,
  input  logic [N-1:0]       fall_mask,
  input  logic               cnt_clr,
  output logic [M-1:0]       io_out,
  output logic [M-1:0]       rise_pulse,
  output logic [M-1:0]       fall_pulse,
  output logic [M-1:0]       conflict,
  output logic               all_high,
  output logic               all_low,
  output logic [M*CNT_W-1:0] trans_cnt
);

  localparam int W = M * N;

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][W-1:0] sync_r;       // [0] is the first capture flop
  logic [W-1:0]                  s_s;          // fully synchronised inputs

  logic                          rise_en_s;    // rise_mask selects something
  logic                          fall_en_s;    // fall_mask selects something
  logic [M-1:0]                  rise_cond_s;
  logic [M-1:0]                  fall_cond_s;

  logic [M-1:0]                  next_out_s;
  logic [M-1:0]                  rise_next_s;
  logic [M-1:0]                  fall_next_s;
  logic [M-1:0]                  conflict_next_s;

  logic [M-1:0]                  io_out_r;
  logic [M-1:0]                  rise_r;
  logic [M-1:0]                  fall_r;
  logic [M-1:0]                  conflict_r;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  // Shift every input bit through SYNC_STAGES flops; reset flushes in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], io_in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Rising / falling conditions
  // ---------------------------------------------------------------------------
  // An all-zero mask disables its direction entirely. Without this gate the
  // "every selected bit" test would be vacuously true.
  assign rise_en_s = (rise_mask != {N{1'b0}});
  assign fall_en_s = (fall_mask != {N{1'b0}});

  // Per-channel evaluation of R_m and F_m on the synchronised vector.
  always_comb begin
    rise_cond_s = '0;
    fall_cond_s = '0;
    for (int m = 0; m < M; m++) begin
      rise_cond_s[m] = rise_en_s && ((s_s[m*N +: N] & rise_mask) == rise_mask);
      fall_cond_s[m] = fall_en_s && ((s_s[m*N +: N] & fall_mask) == {N{1'b0}});
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  // C-element next state. R & F together is a conflict and holds, just as
  // the case where neither condition is true.
  always_comb begin
    next_out_s      = io_out_r;
    rise_next_s     = '0;
    fall_next_s     = '0;
    conflict_next_s = '0;
    for (int m = 0; m < M; m++) begin
      case ({rise_cond_s[m], fall_cond_s[m]})
        2'b10:   next_out_s[m] = 1'b1;
        2'b01:   next_out_s[m] = 1'b0;
        default: next_out_s[m] = io_out_r[m];
      endcase
      rise_next_s[m]     = next_out_s[m] & ~io_out_r[m];
      fall_next_s[m]     = ~next_out_s[m] & io_out_r[m];
      conflict_next_s[m] = rise_cond_s[m] & fall_cond_s[m];
    end
  end

  // ---------------------------------------------------------------------------
  // Output state and event registers
  // ---------------------------------------------------------------------------
  // Pulses are registered with the state, so they line up with the new io_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_out_r   <= '0;
      rise_r     <= '0;
      fall_r     <= '0;
      conflict_r <= '0;
    end else begin
      io_out_r   <= next_out_s;
      rise_r     <= rise_next_s;
      fall_r     <= fall_next_s;
      conflict_r <= conflict_next_s;
    end
  end

  assign io_out     = io_out_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign conflict   = conflict_r;

  // Bank-wide completion flags straight from the state registers.
  assign all_high   = &io_out_r;
  assign all_low    = ~|io_out_r;

  // ---------------------------------------------------------------------------
  // Transition counters (optional)
  // ---------------------------------------------------------------------------
`ifdef MULLER_C_BANK_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [M-1:0][CNT_W-1:0] cnt_r;

  // Saturating per-channel transition counters; a clear beats a coincident transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (cnt_clr) begin
          cnt_r[m] <= '0;
        end else if ((rise_next_s[m] | fall_next_s[m]) && (cnt_r[m] != CNT_MAX)) begin
          cnt_r[m] <= cnt_r[m] + CNT_ONE;
        end else begin
          cnt_r[m] <= cnt_r[m];
        end
      end
    end
  end

  assign trans_cnt = cnt_r;
`else
  // Counters not built: cnt_clr has no effect and the count reads zero.
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign trans_cnt      = '0;
`endif

endmodule

// File: tb/tb_muller_c_bank.sv
// -----------------------------------------------------------------------------
// tb_muller_c_bank
//
// Self-checking bench for muller_c_bank (N=6, M=4, SYNC_STAGES=2, CNT_W=4).
// A behavioural reference model runs one update per rising edge:
//   - a queue models the synchroniser delay;
//   - per-channel arrays hold the expected state, pulses and counts, computed
//     from the C-element rules.
// Directed steps are followed by a randomized phase and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_muller_c_bank;

  localparam int N  = 6;
  localparam int M  = 4;
  localparam int SS = 2;
  localparam int CW = 4;

`ifdef MULLER_C_BANK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [M*N-1:0]  io_in;
  logic [N-1:0]    rise_mask;
  logic [N-1:0]    fall_mask;
  logic            cnt_clr;
  logic [M-1:0]    io_out;
  logic [M-1:0]    rise_pulse;
  logic [M-1:0]    fall_pulse;
  logic [M-1:0]    conflict;
  logic            all_high;
  logic            all_low;
  logic [M*CW-1:0] trans_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit [M*N-1:0] pipe_q[$];
  bit           exp_out  [M];
  bit           exp_rise [M];
  bit           exp_fall [M];
  bit           exp_conf [M];
  int           exp_cnt  [M];

  muller_c_bank #(
    .N(N), .M(M), .SYNC_STAGES(SS), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_in      (io_in),
    .rise_mask  (rise_mask),
    .fall_mask  (fall_mask),
    .cnt_clr    (cnt_clr),
    .io_out     (io_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .conflict   (conflict),
    .all_high   (all_high),
    .all_low    (all_low),
    .trans_cnt  (trans_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run somehow stalls.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < SS; i++) pipe_q.push_back('0);
    for (int m = 0; m < M; m++) begin
      exp_out[m]  = 1'b0;
      exp_rise[m] = 1'b0;
      exp_fall[m] = 1'b0;
      exp_conf[m] = 1'b0;
      exp_cnt[m]  = 0;
    end
  endtask

  // One rising edge of the reference model.
  task automatic model_edge();
    bit [M*N-1:0] s;
    bit r, f, moved;
    int max_cnt;
    max_cnt = (1 << CW) - 1;
    s = pipe_q.pop_front();
    pipe_q.push_back(io_in);
    for (int m = 0; m < M; m++) begin
      r = (rise_mask != 0);
      f = (fall_mask != 0);
      for (int b = 0; b < N; b++) begin
        if (rise_mask[b] && !s[m*N+b]) r = 1'b0;
        if (fall_mask[b] &&  s[m*N+b]) f = 1'b0;
      end
      exp_rise[m] = 1'b0;
      exp_fall[m] = 1'b0;
      exp_conf[m] = r && f;
      moved = 1'b0;
      if (r && !f && !exp_out[m]) begin
        exp_out[m] = 1'b1; exp_rise[m] = 1'b1; moved = 1'b1;
      end
      if (f && !r && exp_out[m] && !moved) begin
        exp_out[m] = 1'b0; exp_fall[m] = 1'b1; moved = 1'b1;
      end
      if (cnt_clr)                          exp_cnt[m] = 0;
      else if (moved && exp_cnt[m] < max_cnt) exp_cnt[m] = exp_cnt[m] + 1;
    end
  endtask

  task automatic check_all();
    logic [M-1:0]    eo, er, ef, ec;
    logic [M*CW-1:0] ecnt;
    for (int m = 0; m < M; m++) begin
      eo[m] = exp_out[m];
      er[m] = exp_rise[m];
      ef[m] = exp_fall[m];
      ec[m] = exp_conf[m];
      ecnt[m*CW +: CW] = CNT_EN ? exp_cnt[m][CW-1:0] : '0;
    end
    chk("io_out",     64'(io_out),     64'(eo));
    chk("rise_pulse", 64'(rise_pulse), 64'(er));
    chk("fall_pulse", 64'(fall_pulse), 64'(ef));
    chk("conflict",   64'(conflict),   64'(ec));
    chk("all_high",   64'(all_high),   64'(&eo));
    chk("all_low",    64'(all_low),    64'(~|eo));
    chk("trans_cnt",  64'(trans_cnt),  64'(ecnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_ch(input int ch, input logic [N-1:0] v);
    io_in[ch*N +: N] = v;
  endtask

  initial begin
    int exp15;
    exp15 = CNT_EN ? 15 : 0;

    // ---------------- reset state ----------------
    rst_n     = 1'b1;
    io_in     = '0;
    rise_mask = 6'h3F;
    fall_mask = 6'h3F;
    cnt_clr   = 1'b0;
    #1 rst_n  = 1'b0;
    model_reset();
    #2;
    chk("rst_io_out",    64'(io_out),    64'(0));
    chk("rst_all_low",   64'(all_low),   64'(1));
    chk("rst_all_high",  64'(all_high),  64'(0));
    chk("rst_trans_cnt", 64'(trans_cnt), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // ---------------- channel 0 rise ----------------
    set_ch(0, 6'h3F);
    tick();
    chk("rise_lat_t0",  64'(io_out[0]), 64'(0));
    tick();
    chk("rise_lat_t1",  64'(io_out[0]), 64'(0));
    tick();
    chk("rise_lat_t2",  64'(io_out[0]), 64'(1));
    chk("rise_pulse0",  64'(rise_pulse[0]), 64'(1));
    chk("rise_cnt0",    64'(trans_cnt[0 +: CW]), 64'(CNT_EN ? 1 : 0));
    tick();
    chk("rise_pulse0_end", 64'(rise_pulse[0]), 64'(0));

    // ---------------- hold with partial inputs, then fall ----------------
    set_ch(0, 6'h15);
    repeat (20) tick();
    chk("hold_partial", 64'(io_out[0]), 64'(1));
    set_ch(0, 6'h00);
    tick();
    tick();
    chk("fall_pre",     64'(io_out[0]), 64'(1));
    tick();
    chk("fall_out0",    64'(io_out[0]), 64'(0));
    chk("fall_pulse0",  64'(fall_pulse[0]), 64'(1));

    // ---------------- asymmetric masks and conflict ----------------
    rise_mask = 6'h03;
    fall_mask = 6'h30;
    set_ch(1, 6'h03);
    repeat (3) tick();
    chk("conf1_a", 64'(conflict[1]), 64'(1));
    chk("hold1_0", 64'(io_out[1]),   64'(0));
    set_ch(1, 6'h33);
    repeat (3) tick();
    chk("rise1",   64'(io_out[1]),   64'(1));
    set_ch(1, 6'h03);
    repeat (3) tick();
    chk("conf1_b", 64'(conflict[1]), 64'(1));
    chk("hold1_1", 64'(io_out[1]),   64'(1));
    set_ch(1, 6'h00);
    repeat (3) tick();
    chk("fall1",   64'(io_out[1]),   64'(0));
    rise_mask = 6'h3F;
    fall_mask = 6'h3F;
    tick();

    // ---------------- counter saturation and clear priority ----------------
    for (int i = 0; i < 20; i++) begin
      set_ch(2, (i % 2 == 0) ? 6'h3F : 6'h00);
      repeat (3) tick();
    end
    chk("sat_cnt2", 64'(trans_cnt[2*CW +: CW]), 64'(exp15));
    set_ch(2, 6'h3F);
    tick();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_out2",  64'(io_out[2]),             64'(1));
    chk("clr_cnt2",  64'(trans_cnt[2*CW +: CW]), 64'(0));
    tick();

    // ---------------- randomized phase ----------------
    for (int t = 0; t < 400; t++) begin
      for (int ch = 0; ch < M; ch++) begin
        if ($urandom_range(2) == 0) begin
          case ($urandom_range(3))
            0:       set_ch(ch, 6'h00);
            1:       set_ch(ch, 6'h3F);
            default: set_ch(ch, N'($urandom));
          endcase
        end
      end
      if (t % 50 == 25) begin
        case ($urandom_range(3))
          0:       begin rise_mask = 6'h3F; fall_mask = 6'h3F; end
          1:       begin rise_mask = 6'h00; fall_mask = 6'h3F; end
          2:       begin rise_mask = 6'h07; fall_mask = 6'h00; end
          default: begin rise_mask = N'($urandom); fall_mask = N'($urandom); end
        endcase
      end
      cnt_clr = ($urandom_range(31) == 0);
      tick();
    end
    cnt_clr   = 1'b0;
    rise_mask = 6'h3F;
    fall_mask = 6'h3F;

    // ---------------- asynchronous reset mid-operation ----------------
    io_in = {M{6'h3F}};
    repeat (4) tick();
    chk("pre_rst_out",      64'(io_out),   64'(4'hF));
    chk("pre_rst_all_high", 64'(all_high), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_io_out",   64'(io_out),     64'(0));
    chk("arst_all_low",  64'(all_low),    64'(1));
    chk("arst_all_high", 64'(all_high),   64'(0));
    chk("arst_rise",     64'(rise_pulse), 64'(0));
    chk("arst_fall",     64'(fall_pulse), 64'(0));
    chk("arst_conf",     64'(conflict),   64'(0));
    chk("arst_cnt",      64'(trans_cnt),  64'(0));
    model_reset();
    io_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
